// File: rtl/axi_mm_axis_reader.sv
// AXI4 read-burst engine that replays a (address, byte length) command from memory as one AXI-Stream frame.
// Bursts are capped by MAX_BURST_LEN and never cross a 4KB boundary; one command in flight.
module axi_mm_axis_reader #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 34,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  status_done,
  output logic                  status_error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
  localparam int OFF_W   = $clog2(KEEP_WIDTH);
  localparam int BEATS_W = LEN_WIDTH - OFF_W + 1;
  localparam int CW      = (BEATS_W > 13) ? BEATS_W : 13;

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, RDATA = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BEATS_W-1:0]     beats_rem_q, beats_rem_d;
  logic [8:0]             burst_rem_q, burst_rem_d;
  logic [OFF_W-1:0]       tail_q, tail_d;
  logic                   error_q, error_d;
  logic                   cmd_ready_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic [KEEP_WIDTH-1:0]  tkeep_q;
  logic                   tlast_q, tvalid_q;

  logic [LEN_WIDTH:0]     len_round;
  logic [12:0]            page_bytes;
  logic [CW-1:0]          page_beats, burst_n;
  logic [KEEP_WIDTH-1:0]  tail_mask;
  logic                   r_hs, last_beat;
  logic                   unused_ok;

  assign unused_ok = ^{m_axi_rid, m_axi_rlast, cmd_addr[OFF_W-1:0]};

  assign len_round  = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(KEEP_WIDTH - 1);
  assign page_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
  assign page_beats = CW'(page_bytes >> OFF_W);
  assign tail_mask  = (KEEP_WIDTH'(1) << tail_q) - KEEP_WIDTH'(1);
  assign last_beat  = (beats_rem_q == BEATS_W'(1));

  always_comb begin
    burst_n = CW'(beats_rem_q);
    if (burst_n > CW'(MAX_BURST_LEN)) burst_n = CW'(MAX_BURST_LEN);
    if (burst_n > page_beats)         burst_n = page_beats;
  end

  // R is only accepted when the single output register is free or being drained this cycle.
  assign m_axi_rready = (state_q == RDATA) && (!tvalid_q || m_axis_tready);
  assign r_hs         = m_axi_rvalid && m_axi_rready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_rem_d = beats_rem_q;
    burst_rem_d = burst_rem_q;
    tail_d      = tail_q;
    error_d     = error_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = {cmd_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
          beats_rem_d = len_round[LEN_WIDTH:OFF_W];
          tail_d      = cmd_len[OFF_W-1:0];
          error_d     = 1'b0;
          state_d     = (cmd_len == '0) ? DONE : AR;
        end
      end
      AR: begin
        if (m_axi_arready) begin
          addr_d      = addr_q + (ADDR_WIDTH'(burst_n) << OFF_W);
          burst_rem_d = 9'(burst_n);
          state_d     = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          beats_rem_d = beats_rem_q - BEATS_W'(1);
          burst_rem_d = burst_rem_q - 9'd1;
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          if (burst_rem_q == 9'd1) state_d = last_beat ? DONE : AR;
        end
      end
      DONE: begin
        if (!tvalid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beats_rem_q <= '0;
      burst_rem_q <= '0;
      tail_q      <= '0;
      error_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_rem_q <= beats_rem_d;
      burst_rem_q <= burst_rem_d;
      tail_q      <= tail_d;
      error_q     <= error_d;
      cmd_ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (r_hs) begin
      tdata_q  <= m_axi_rdata;
      tkeep_q  <= (last_beat && tail_q != '0) ? tail_mask : '1;
      tlast_q  <= last_beat;
      tvalid_q <= 1'b1;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign status_done   = (state_q == DONE) && !tvalid_q;
  assign status_error  = error_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(burst_n - CW'(1));
  assign m_axi_arsize  = 3'(OFF_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = (state_q == AR);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_mm_axis_reader.sv
// Bench for axi_mm_axis_reader: memory-model AXI slave, AXIS scoreboard, table-driven commands,
// mid-burst reset and randomized commands checked against a burst/beat reference model.
module tb_axi_mm_axis_reader;
  localparam int DW = 512, KW = 64, AW = 34, IW = 8, LW = 16, MBL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid, cmd_ready, status_done, status_error;
  logic [IW-1:0] m_axi_arid, m_axi_rid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize, m_axi_arprot;
  logic [1:0]    m_axi_arburst, m_axi_rresp, dbg_state_o;
  logic [3:0]    m_axi_arcache;
  logic          m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata, m_axis_tdata;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;

  axi_mm_axis_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
                       .MAX_BURST_LEN(MBL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .status_done(status_done), .status_error(status_error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .dbg_state_o(dbg_state_o)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;
  typedef struct {
    logic [AW-1:0] addr; int len; bit rnd; int errb;
    int ars; int beats; logic [KW-1:0] keep; bit err;
  } vec_t;

  ar_t           exp_ar_q[$];
  beat_t         exp_q[$];
  logic [AW-1:0] pend_addr_q[$];
  int            pend_n_q[$];

  int checks = 0, passed = 0;
  int ar_cnt = 0, beat_cnt = 0, done_cnt = 0, cmd_beat_idx = 0, err_beat = -1, cur_left = 0;
  bit rnd_mode = 0, r_taken = 0, ar_stall = 0, t_stall = 0, err_at_done = 0;
  logic [AW-1:0] cur_addr = '0, ar_prev_addr = '0;
  logic [7:0]    ar_prev_len = '0;
  logic [KW-1:0] last_keep = '0;
  beat_t         t_prev;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_check(input string name);
    checks++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = a[31:0] ^ (32'h9E3779B9 * 32'(k + 1)) ^ {30'd0, a[33:32]};
    return w;
  endfunction

  // Reference: frame = consecutive memory words; bursts split by count cap and 4KB pages.
  task automatic model_cmd(input logic [AW-1:0] addr, input int len, output int n_ars, output int n_beats);
    logic [AW-1:0] a;
    int rem, tail, page, n;
    beat_t b;
    a = {addr[AW-1:6], 6'd0};
    rem = (len + KW - 1) / KW;
    tail = len % KW;
    n_beats = rem;
    n_ars = 0;
    for (int i = 0; i < n_beats; i++) begin
      b.data = mem_word(a + AW'(i * KW));
      b.keep = (i == n_beats - 1 && tail != 0) ? ({KW{1'b1}} >> (KW - tail)) : {KW{1'b1}};
      b.last = (i == n_beats - 1);
      exp_q.push_back(b);
    end
    while (rem > 0) begin
      page = (4096 - int'(a % 4096)) / KW;
      n = rem;
      if (n > MBL) n = MBL;
      if (n > page) n = page;
      exp_ar_q.push_back('{a, 8'(n - 1)});
      a = a + AW'(n * KW);
      rem = rem - n;
      n_ars++;
    end
  endtask

  // Memory slave, stream sink and scoreboard: sample mid-cycle, drive 1 time unit after the edge.
  initial begin
    ar_t e;
    beat_t eb;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rid = '0; m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      r_taken = 0;
      if (!rst_n) begin
        pend_addr_q.delete(); pend_n_q.delete();
        cur_left = 0; ar_stall = 0; t_stall = 0;
      end else begin
        if (ar_stall) check("ar_stable", DW'({m_axi_arvalid, m_axi_araddr, m_axi_arlen}),
                            DW'({1'b1, ar_prev_addr, ar_prev_len}));
        ar_stall = m_axi_arvalid && !m_axi_arready;
        ar_prev_addr = m_axi_araddr;
        ar_prev_len = m_axi_arlen;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_cnt++;
          if (exp_ar_q.size() == 0) fail_check("ar_unexpected");
          else begin
            e = exp_ar_q.pop_front();
            check("araddr", DW'(m_axi_araddr), DW'(e.addr));
            check("arlen", DW'(m_axi_arlen), DW'(e.len));
          end
          check("ar_const", DW'({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}),
                DW'({8'd0, 3'd6, 2'd1, 1'b0, 4'd0, 3'd0}));
          pend_addr_q.push_back(m_axi_araddr);
          pend_n_q.push_back(int'(m_axi_arlen) + 1);
        end
        if (m_axi_rvalid && m_axi_rready) begin
          r_taken = 1;
          cur_left--;
          cur_addr = cur_addr + AW'(KW);
          cmd_beat_idx++;
        end
        if (t_stall) begin
          check("axis_hold_valid", DW'(m_axis_tvalid), DW'(1));
          check("axis_hold_data", m_axis_tdata, t_prev.data);
          check("axis_hold_keep_last", DW'({m_axis_tkeep, m_axis_tlast}), DW'({t_prev.keep, t_prev.last}));
        end
        t_stall = m_axis_tvalid && !m_axis_tready;
        t_prev = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready) begin
          beat_cnt++;
          if (m_axis_tlast) last_keep = m_axis_tkeep;
          if (exp_q.size() == 0) fail_check("beat_unexpected");
          else begin
            eb = exp_q.pop_front();
            check("beat_data", m_axis_tdata, eb.data);
            check("beat_keep", DW'(m_axis_tkeep), DW'(eb.keep));
            check("beat_last", DW'(m_axis_tlast), DW'(eb.last));
          end
        end
        if (status_done) begin
          done_cnt++;
          err_at_done = status_error;
        end
      end
      @(posedge clk);
      #1;
      m_axi_arready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!rst_n) m_axi_rvalid = 1'b0;
      else if (!(m_axi_rvalid && !r_taken)) begin
        if (cur_left == 0 && pend_n_q.size() > 0) begin
          cur_addr = pend_addr_q.pop_front();
          cur_left = pend_n_q.pop_front();
        end
        if (cur_left > 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata = mem_word(cur_addr);
          m_axi_rlast = (cur_left == 1);
          m_axi_rresp = (cmd_beat_idx == err_beat) ? 2'b10 : 2'b00;
        end else m_axi_rvalid = 1'b0;
      end
    end
  end

  task automatic issue_cmd(input logic [AW-1:0] addr, input int len, input string name);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!cmd_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cmd_ready) fail_check({name, "_cmd_ready_timeout"});
    cmd_addr = addr;
    cmd_len = LW'(len);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [AW-1:0] addr, input int len, input bit rnd, input int errb,
                         input int exp_ars, input int exp_beats, input bit chk_keep,
                         input logic [KW-1:0] exp_keep, input bit exp_err, input string name);
    int m_ars, m_beats, d0, k;
    exp_q.delete(); exp_ar_q.delete();
    rnd_mode = rnd; err_beat = errb; cmd_beat_idx = 0;
    ar_cnt = 0; beat_cnt = 0; d0 = done_cnt;
    model_cmd(addr, len, m_ars, m_beats);
    if (exp_ars < 0) exp_ars = m_ars;
    if (exp_beats < 0) exp_beats = m_beats;
    issue_cmd(addr, len, name);
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == d0) fail_check({name, "_done_timeout"});
    check({name, "_ar_count"}, DW'(ar_cnt), DW'(exp_ars));
    check({name, "_beat_count"}, DW'(beat_cnt), DW'(exp_beats));
    check({name, "_beats_missing"}, DW'(exp_q.size()), DW'(0));
    check({name, "_error"}, DW'(err_at_done), DW'(exp_err));
    if (chk_keep && exp_beats > 0) check({name, "_last_keep"}, DW'(last_keep), DW'(exp_keep));
    @(negedge clk);
    check({name, "_done_one_cycle"}, DW'(status_done), DW'(0));
  endtask

  vec_t vecs[8];

  initial begin
    int k, len, beats, errb;
    logic [AW-1:0] addr;
    vecs[0] = '{34'h1000, 64,   0, -1, 1, 1,  {KW{1'b1}},             0};
    vecs[1] = '{34'h0,    1100, 0, -1, 2, 18, 64'hFFF,                0};
    vecs[2] = '{34'hF80,  256,  0, -1, 2, 4,  {KW{1'b1}},             0};
    vecs[3] = '{34'h2000, 2000, 1, -1, 2, 32, 64'hFFFF,               0};
    vecs[4] = '{34'h3000, 192,  0, 1,  1, 3,  {KW{1'b1}},             1};
    vecs[5] = '{34'h3000, 0,    0, -1, 0, 0,  {KW{1'b0}},             0};
    vecs[6] = '{34'hFC0,  130,  1, -1, 2, 3,  64'h3,                  0};
    vecs[7] = '{34'h7C00, 3000, 1, -1, 3, 47, 64'h00FF_FFFF_FFFF_FFFF, 0};
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs", DW'({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep,
                                cmd_ready, status_done, status_error, dbg_state_o}), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_before_edge", DW'(cmd_ready), DW'(0));
    @(negedge clk);
    check("cmd_ready_after_edge", DW'(cmd_ready), DW'(1));

    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].addr, vecs[i].len, vecs[i].rnd, vecs[i].errb, vecs[i].ars, vecs[i].beats,
              1'b1, vecs[i].keep, vecs[i].err, $sformatf("vec%0d", i));

    // Reset in the middle of a 16-beat burst, then a clean command.
    exp_q.delete(); exp_ar_q.delete();
    rnd_mode = 1; err_beat = -1; cmd_beat_idx = 0; ar_cnt = 0; beat_cnt = 0;
    model_cmd(34'h9000, 1024, k, beats);
    issue_cmd(34'h9000, 1024, "midrst");
    k = 0;
    while (beat_cnt < 3 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (beat_cnt < 3) fail_check("midrst_progress_timeout");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_async_outputs", DW'({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep,
                                       cmd_ready, status_done, status_error}), DW'(0));
    exp_q.delete(); exp_ar_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cmd(34'h9000, 1024, 1, -1, 1, 16, 1'b1, {KW{1'b1}}, 0, "after_rst");

    for (int i = 0; i < 8; i++) begin
      addr = AW'($urandom_range(0, 'h3FFF)) << 6;
      len = $urandom_range(0, 1500);
      beats = (len + KW - 1) / KW;
      errb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, beats) : -1;
      run_cmd(addr, len, 1, errb, -1, -1, 1'b0, '0, (errb >= 0 && errb < beats),
              $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
